// File: rtl/alu_control_mc_pkg.sv
// Shared encodings for the ALU control block: ALUOp classes, R-type funct
// values, ALUCtl codes, multiply/divide op codes and the FSM state type.
package alu_pkg;

   // ALUOp classes from main control
   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_RTYPE = 3'b010;
   localparam logic [2:0] OP_ANDI  = 3'b011;
   localparam logic [2:0] OP_ORI   = 3'b100;
   localparam logic [2:0] OP_SLTI  = 3'b101;

   // R-type funct field values
   localparam logic [5:0] F_SLL   = 6'd0;
   localparam logic [5:0] F_SRL   = 6'd2;
   localparam logic [5:0] F_SRA   = 6'd3;
   localparam logic [5:0] F_MULT  = 6'd24;
   localparam logic [5:0] F_MULTU = 6'd25;
   localparam logic [5:0] F_DIV   = 6'd26;
   localparam logic [5:0] F_DIVU  = 6'd27;
   localparam logic [5:0] F_ADD   = 6'd32;
   localparam logic [5:0] F_SUB   = 6'd34;
   localparam logic [5:0] F_AND   = 6'd36;
   localparam logic [5:0] F_OR    = 6'd37;
   localparam logic [5:0] F_XOR   = 6'd38;
   localparam logic [5:0] F_NOR   = 6'd39;
   localparam logic [5:0] F_SLT   = 6'd42;
   localparam logic [5:0] F_SLTU  = 6'd43;

   // ALUCtl codes
   localparam logic [3:0] CTL_AND  = 4'b0000;
   localparam logic [3:0] CTL_OR   = 4'b0001;
   localparam logic [3:0] CTL_ADD  = 4'b0010;
   localparam logic [3:0] CTL_XOR  = 4'b0011;
   localparam logic [3:0] CTL_SLL  = 4'b0100;
   localparam logic [3:0] CTL_SRL  = 4'b0101;
   localparam logic [3:0] CTL_SUB  = 4'b0110;
   localparam logic [3:0] CTL_SLT  = 4'b0111;
   localparam logic [3:0] CTL_MUL  = 4'b1000;
   localparam logic [3:0] CTL_DIV  = 4'b1001;
   localparam logic [3:0] CTL_SLTU = 4'b1011;
   localparam logic [3:0] CTL_NOR  = 4'b1100;
   localparam logic [3:0] CTL_SRA  = 4'b1101;
   localparam logic [3:0] CTL_ILL  = 4'b1111;

   // Multiply/divide unit op codes; bit 1 set means a divide
   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   localparam int CNT_W = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_control_mc_if.sv
// Request/response bundle between main control and the ALU control block.
interface alu_control_mc_if #(
   parameter int CTL_W = 4
);
   logic             InValid;
   logic [2:0]       ALUOp;
   logic [5:0]       FuncCode;
   logic             Flush;
   logic [CTL_W-1:0] ALUCtl;
   logic             CtlValid;
   logic             IllegalOp;
   logic             MdStart;
   logic [1:0]       MdOp;
   logic             Stall;

   modport master (
      output InValid, ALUOp, FuncCode, Flush,
      input  ALUCtl, CtlValid, IllegalOp, MdStart, MdOp, Stall
   );

   modport slave (
      input  InValid, ALUOp, FuncCode, Flush,
      output ALUCtl, CtlValid, IllegalOp, MdStart, MdOp, Stall
   );
endinterface

// File: rtl/alu_control_mc_decode.sv
// Pure combinational decode of ALUOp/funct into an ALU control code, with a
// flag for multi-cycle multiply/divide ops and one for illegal encodings.
module alu_func_decode
   import alu_pkg::*;
(
   input  logic [2:0] alu_op,
   input  logic [5:0] funct,
   output logic [3:0] code,
   output logic       is_md,
   output logic [1:0] md_op,
   output logic       illegal
);

   // Anything not matched falls through to the illegal code
   always_comb begin
      code    = CTL_ILL;
      is_md   = 1'b0;
      md_op   = MD_MULT;
      illegal = 1'b0;
      case (alu_op)
         OP_ADD:  code = CTL_ADD;
         OP_SUB:  code = CTL_SUB;
         OP_ANDI: code = CTL_AND;
         OP_ORI:  code = CTL_OR;
         OP_SLTI: code = CTL_SLT;
         OP_RTYPE: begin
            case (funct)
               F_ADD:   code = CTL_ADD;
               F_SUB:   code = CTL_SUB;
               F_AND:   code = CTL_AND;
               F_OR:    code = CTL_OR;
               F_XOR:   code = CTL_XOR;
               F_NOR:   code = CTL_NOR;
               F_SLT:   code = CTL_SLT;
               F_SLTU:  code = CTL_SLTU;
               F_SLL:   code = CTL_SLL;
               F_SRL:   code = CTL_SRL;
               F_SRA:   code = CTL_SRA;
               F_MULT:  begin is_md = 1'b1; md_op = MD_MULT;  code = CTL_MUL; end
               F_MULTU: begin is_md = 1'b1; md_op = MD_MULTU; code = CTL_MUL; end
               F_DIV:   begin is_md = 1'b1; md_op = MD_DIV;   code = CTL_DIV; end
               F_DIVU:  begin is_md = 1'b1; md_op = MD_DIVU;  code = CTL_DIV; end
               default: illegal = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_control_mc.sv
// ALU control with multi-cycle multiply/divide sequencing. Single-cycle ops
// produce a registered ALUCtl one edge after acceptance; MULT/DIV ops fire a
// start pulse, stall upstream for exactly LAT cycles, then report completion.
module alu_control_mc
   import alu_pkg::*;
#(
   parameter int CTL_W   = 4,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32
)(
   input logic              clk,
   input logic              rst_n,
   alu_control_mc_if.slave  bus
);

   // Counter is loaded with LAT-1 so BUSY lasts exactly LAT cycles
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CTL_W-1:0] ctl, ctl_nxt;
   logic             vld, vld_nxt;
   logic             ill, ill_nxt;
   logic             start, start_nxt;
   logic [1:0]       mdop, mdop_nxt;

   logic [3:0]       dec_code;
   logic             dec_md;
   logic [1:0]       dec_mdop;
   logic             dec_ill;

   alu_func_decode u_dec (
      .alu_op  (bus.ALUOp),
      .funct   (bus.FuncCode),
      .code    (dec_code),
      .is_md   (dec_md),
      .md_op   (dec_mdop),
      .illegal (dec_ill)
   );

   // Next-state and next-output decode; Flush overrides every state
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ctl_nxt   = ctl;
      vld_nxt   = 1'b0;
      ill_nxt   = 1'b0;
      start_nxt = 1'b0;
      mdop_nxt  = mdop;
      if (bus.Flush) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            ST_BUSY: begin
               if (cnt == '0) begin
                  state_nxt = ST_DONE;
                  ctl_nxt   = CTL_W'(mdop[1] ? CTL_DIV : CTL_MUL);
                  vld_nxt   = 1'b1;
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
            // IDLE and DONE both accept a new op
            default: begin
               state_nxt = ST_IDLE;
               if (bus.InValid) begin
                  if (dec_md) begin
                     state_nxt = ST_BUSY;
                     start_nxt = 1'b1;
                     mdop_nxt  = dec_mdop;
                     cnt_nxt   = dec_mdop[1] ? DIV_CNT : MUL_CNT;
                  end else begin
                     ctl_nxt = CTL_W'(dec_code);
                     vld_nxt = 1'b1;
                     ill_nxt = dec_ill;
                  end
               end
            end
         endcase
      end
   end

   // State, counter and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         ctl   <= '0;
         vld   <= 1'b0;
         ill   <= 1'b0;
         start <= 1'b0;
         mdop  <= MD_MULT;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ctl   <= ctl_nxt;
         vld   <= vld_nxt;
         ill   <= ill_nxt;
         start <= start_nxt;
         mdop  <= mdop_nxt;
      end
   end

   assign bus.ALUCtl    = ctl;
   assign bus.CtlValid  = vld;
   assign bus.IllegalOp = ill;
   assign bus.MdStart   = start;
   assign bus.MdOp      = mdop;
   // Stall depends on state alone so there is no input-to-output path
   assign bus.Stall     = (state == ST_BUSY);

endmodule

// File: tb/tb_alu_control_mc.sv
// Bench for alu_control_mc: decode table, multi-cycle corner sequences, and
// a randomized run against a cycle-timeline reference model.
module tb_alu_control_mc;

   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 32;
   localparam int NR      = 500;
   localparam int NA      = NR + 80;

   logic clk;
   logic rst_n;

   alu_control_mc_if #(.CTL_W(4)) bus();

   alu_control_mc #(.CTL_W(4), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic [2:0] op;
      logic [5:0] fn;
      logic [3:0] ctl;
      logic       ill;
   } vec_t;

   vec_t tbl[21];

   // expected timeline for the random phase, indexed by cycle
   logic       exp_vld  [NA];
   logic [3:0] exp_code [NA];
   logic       exp_ill  [NA];
   logic       exp_start[NA];
   logic       exp_mdset[NA];
   logic [1:0] exp_mdop [NA];
   logic       exp_stall[NA];
   logic [3:0] last_ctl;
   logic [1:0] last_mdop;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn, input logic fl);
      bus.InValid  = v;
      bus.ALUOp    = op;
      bus.FuncCode = fn;
      bus.Flush    = fl;
   endtask

   // Reference decode straight from the opcode/funct tables
   function automatic void ref_dec(input logic [2:0] op, input logic [5:0] fn,
                                   output logic [3:0] code, output logic ill,
                                   output logic md, output logic [1:0] mop);
      code = 4'b1111; ill = 1'b1; md = 1'b0; mop = 2'b00;
      if (op == 3'd0) begin code = 4'b0010; ill = 1'b0; end
      else if (op == 3'd1) begin code = 4'b0110; ill = 1'b0; end
      else if (op == 3'd3) begin code = 4'b0000; ill = 1'b0; end
      else if (op == 3'd4) begin code = 4'b0001; ill = 1'b0; end
      else if (op == 3'd5) begin code = 4'b0111; ill = 1'b0; end
      else if (op == 3'd2) begin
         ill = 1'b0;
         case (fn)
            6'd32: code = 4'b0010;
            6'd34: code = 4'b0110;
            6'd36: code = 4'b0000;
            6'd37: code = 4'b0001;
            6'd38: code = 4'b0011;
            6'd39: code = 4'b1100;
            6'd42: code = 4'b0111;
            6'd43: code = 4'b1011;
            6'd0:  code = 4'b0100;
            6'd2:  code = 4'b0101;
            6'd3:  code = 4'b1101;
            6'd24, 6'd25, 6'd26, 6'd27: begin md = 1'b1; mop = 2'(fn - 6'd24); end
            default: ill = 1'b1;
         endcase
      end
   endfunction

   // Schedule the observable effects of the input presented in cycle k
   task automatic model_in(input int k, input logic v, input logic [2:0] op, input logic [5:0] fn);
      logic [3:0] code;
      logic ill, md;
      logic [1:0] mop;
      int lat;
      if (!v || exp_stall[k]) return;
      ref_dec(op, fn, code, ill, md, mop);
      if (md) begin
         lat = mop[1] ? DIV_LAT : MUL_LAT;
         exp_start[k+1] = 1'b1;
         exp_mdset[k+1] = 1'b1;
         exp_mdop[k+1]  = mop;
         for (int j = 1; j <= lat; j++) exp_stall[k+j] = 1'b1;
         exp_vld[k+lat+1]  = 1'b1;
         exp_code[k+lat+1] = mop[1] ? 4'b1001 : 4'b1000;
      end else begin
         exp_vld[k+1]  = 1'b1;
         exp_code[k+1] = code;
         exp_ill[k+1]  = ill;
      end
   endtask

   task automatic model_chk(input int c);
      if (exp_vld[c])   last_ctl  = exp_code[c];
      if (exp_mdset[c]) last_mdop = exp_mdop[c];
      chk("rand", {bus.CtlValid, bus.ALUCtl, bus.IllegalOp, bus.MdStart, bus.MdOp, bus.Stall},
          {exp_vld[c], last_ctl, exp_ill[c], exp_start[c], last_mdop, exp_stall[c]});
   endtask

   initial begin
      int stall_n, starts, vld_n;
      logic [5:0] fl[11];
      logic v;
      logic [2:0] op;
      logic [5:0] fn;
      int r;

      tbl[0]  = '{3'b000, 6'd0,  4'b0010, 1'b0};
      tbl[1]  = '{3'b001, 6'd0,  4'b0110, 1'b0};
      tbl[2]  = '{3'b011, 6'd0,  4'b0000, 1'b0};
      tbl[3]  = '{3'b100, 6'd0,  4'b0001, 1'b0};
      tbl[4]  = '{3'b101, 6'd0,  4'b0111, 1'b0};
      tbl[5]  = '{3'b010, 6'd42, 4'b0111, 1'b0};
      tbl[6]  = '{3'b010, 6'd32, 4'b0010, 1'b0};
      tbl[7]  = '{3'b010, 6'd34, 4'b0110, 1'b0};
      tbl[8]  = '{3'b010, 6'd36, 4'b0000, 1'b0};
      tbl[9]  = '{3'b010, 6'd37, 4'b0001, 1'b0};
      tbl[10] = '{3'b010, 6'd38, 4'b0011, 1'b0};
      tbl[11] = '{3'b010, 6'd39, 4'b1100, 1'b0};
      tbl[12] = '{3'b010, 6'd43, 4'b1011, 1'b0};
      tbl[13] = '{3'b010, 6'd0,  4'b0100, 1'b0};
      tbl[14] = '{3'b010, 6'd2,  4'b0101, 1'b0};
      tbl[15] = '{3'b010, 6'd3,  4'b1101, 1'b0};
      tbl[16] = '{3'b010, 6'd50, 4'b1111, 1'b1};
      tbl[17] = '{3'b111, 6'd0,  4'b1111, 1'b1};
      tbl[18] = '{3'b110, 6'd5,  4'b1111, 1'b1};
      tbl[19] = '{3'b010, 6'd1,  4'b1111, 1'b1};
      tbl[20] = '{3'b000, 6'd50, 4'b0010, 1'b0};

      fl = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43, 6'd0, 6'd2, 6'd3};

      // reset state
      rst_n = 1'b0;
      drive(1'b0, 3'd0, 6'd0, 1'b0);
      #1;
      chk("reset", {bus.ALUCtl, bus.CtlValid, bus.IllegalOp, bus.MdStart, bus.MdOp, bus.Stall}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // decode table, applied back to back (first op on first edge after reset)
      drive(1'b1, tbl[0].op, tbl[0].fn, 1'b0);
      for (int i = 0; i < 21; i++) begin
         tick();
         chk($sformatf("decode[%0d]", i),
             {bus.CtlValid, bus.ALUCtl, bus.IllegalOp, bus.Stall, bus.MdStart},
             {1'b1, tbl[i].ctl, tbl[i].ill, 1'b0, 1'b0});
         if (i < 20) drive(1'b1, tbl[i+1].op, tbl[i+1].fn, 1'b0);
         else        drive(1'b0, 3'd0, 6'd0, 1'b0);
      end

      // DIV: one start pulse, 32 stall cycles, then completion code
      tick();
      drive(1'b1, 3'b010, 6'd26, 1'b0);
      tick();
      chk("div_start", {bus.MdStart, bus.MdOp, bus.Stall, bus.CtlValid}, {1'b1, 2'b10, 1'b1, 1'b0});
      drive(1'b0, 3'd0, 6'd0, 1'b0);
      stall_n = 0; starts = 0;
      for (int i = 0; i < 100 && bus.Stall; i++) begin
         stall_n++;
         starts += int'(bus.MdStart);
         tick();
      end
      chk("div_stall_len", stall_n, DIV_LAT);
      chk("div_start_cnt", starts, 1);
      chk("div_done", {bus.CtlValid, bus.ALUCtl, bus.IllegalOp, bus.MdOp, bus.Stall},
          {1'b1, 4'b1001, 1'b0, 2'b10, 1'b0});

      // MULT, with ADD held during BUSY and taken in the DONE cycle
      drive(1'b1, 3'b010, 6'd24, 1'b0);
      tick();
      chk("mul_start", {bus.MdStart, bus.MdOp, bus.Stall}, {1'b1, 2'b00, 1'b1});
      drive(1'b1, 3'b010, 6'd32, 1'b0);
      stall_n = 0; starts = 0;
      for (int i = 0; i < 100 && bus.Stall; i++) begin
         stall_n++;
         starts += int'(bus.MdStart);
         tick();
      end
      chk("mul_stall_len", stall_n, MUL_LAT);
      chk("mul_start_cnt", starts, 1);
      chk("mul_done", {bus.CtlValid, bus.ALUCtl, bus.Stall}, {1'b1, 4'b1000, 1'b0});
      tick();
      chk("add_after_mul", {bus.CtlValid, bus.ALUCtl, bus.Stall, bus.MdStart}, {1'b1, 4'b0010, 1'b0, 1'b0});
      drive(1'b0, 3'd0, 6'd0, 1'b0);
      tick();
      chk("ctl_hold", {bus.CtlValid, bus.ALUCtl, bus.MdOp}, {1'b0, 4'b0010, 2'b00});

      // Flush at BUSY cycle 10 of a DIV
      drive(1'b1, 3'b010, 6'd26, 1'b0);
      tick();
      drive(1'b0, 3'd0, 6'd0, 1'b0);
      repeat (9) tick();
      chk("div_busy10", bus.Stall, 1'b1);
      bus.Flush = 1'b1;
      tick();
      bus.Flush = 1'b0;
      chk("flush_busy", {bus.Stall, bus.CtlValid, bus.MdStart}, 3'b000);
      vld_n = 0;
      for (int i = 0; i < 40; i++) begin
         vld_n += int'(bus.CtlValid) + int'(bus.Stall);
         tick();
      end
      chk("flush_quiet", vld_n, 0);

      // Flush in IDLE drops the presented op
      drive(1'b1, 3'b001, 6'd0, 1'b1);
      tick();
      chk("flush_idle", {bus.CtlValid, bus.ALUCtl}, {1'b0, 4'b0010});
      drive(1'b0, 3'd0, 6'd0, 1'b0);
      tick();
      chk("flush_idle_after", bus.CtlValid, 1'b0);

      // Reset mid-MULT clears outputs immediately and abandons the op
      drive(1'b1, 3'b010, 6'd25, 1'b0);
      tick();
      drive(1'b0, 3'd0, 6'd0, 1'b0);
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_mul", {bus.ALUCtl, bus.CtlValid, bus.IllegalOp, bus.MdStart, bus.MdOp, bus.Stall}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      vld_n = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         vld_n += int'(bus.CtlValid) + int'(bus.Stall);
      end
      chk("rst_no_done", vld_n, 0);

      // Randomized run against the timeline model, from a fresh reset
      rst_n = 1'b0;
      for (int i = 0; i < NA; i++) begin
         exp_vld[i] = 0; exp_code[i] = 0; exp_ill[i] = 0; exp_start[i] = 0;
         exp_mdset[i] = 0; exp_mdop[i] = 0; exp_stall[i] = 0;
      end
      last_ctl = 4'd0;
      last_mdop = 2'd0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < NR; k++) begin
         v = ($urandom % 4) != 0;
         r = int'($urandom % 16);
         if (r < 3) begin
            op = 3'($urandom);
            fn = 6'($urandom);
         end else begin
            op = 3'b010;
            if (r < 5)                fn = 6'(24 + ($urandom % 4));
            else if ($urandom % 5 == 0) fn = 6'($urandom);
            else                      fn = fl[$urandom % 11];
         end
         model_in(k, v, op, fn);
         drive(v, op, fn, 1'b0);
         tick();
         model_chk(k + 1);
      end
      drive(1'b0, 3'd0, 6'd0, 1'b0);
      for (int k = NR; k < NR + 40; k++) begin
         tick();
         model_chk(k + 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/alu_control_mc.md
ALU_CONTROL_MC -- requirements
Module: alu_control_mc

Interface
REQ-001 Parameter CTL_W, default 4, width of ALUCtl.
REQ-002 Parameter MUL_LAT, default 4, busy cycles for MULT/MULTU (legal range 1..64).
REQ-003 Parameter DIV_LAT, default 32, busy cycles for DIV/DIVU (legal range 1..64).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 InValid  input  1  ALUOp/FuncCode valid this cycle.
REQ-007 ALUOp  input  3  operation class from main control.
REQ-008 FuncCode  input  6  R-type funct field.
REQ-009 Flush  input  1  abort any operation in progress.
REQ-010 ALUCtl  output  CTL_W  registered ALU control code.
REQ-011 CtlValid  output  1  ALUCtl valid this cycle.
REQ-012 IllegalOp  output  1  qualifies CtlValid: unrecognised encoding.
REQ-013 MdStart  output  1  one-cycle start pulse to the multiply/divide unit.
REQ-014 MdOp  output  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; held until the operation completes.
REQ-015 Stall  output  1  upstream SHALL hold its inputs while high.

Function
REQ-016 ALUOp decode: 000 ADD 0010; 001 SUB 0110; 010 R-type, per funct; 011 ANDI 0000; 100 ORI 0001; 101 SLTI 0111; 110/111 illegal.
REQ-017 R-type funct decode: 32 ADD 0010; 34 SUB 0110; 36 AND 0000; 37 OR 0001; 38 XOR 0011; 39 NOR 1100; 42 SLT 0111; 43 SLTU 1011; 0 SLL 0100; 2 SRL 0101; 3 SRA 1101.
REQ-018 R-type funct decode, multi-cycle: 24 MULT; 25 MULTU; 26 DIV; 27 DIVU.
REQ-019 Any other encoding is illegal: ALUCtl=1111 and IllegalOp=1, both qualified by CtlValid.
REQ-020 FSM states: IDLE, BUSY, DONE.
REQ-021 IDLE, single-cycle op accepted: ALUCtl and CtlValid=1 on the next edge (latency 1); back-to-back ops sustain one per cycle.
REQ-022 IDLE, multi-cycle op accepted: next edge gives MdStart=1 for one cycle, MdOp set, counter loaded with LAT-1, state BUSY, CtlValid=0.
REQ-023 BUSY: Stall=1; counter decrements each cycle; InValid ignored; at counter=0 the FSM moves to DONE.
REQ-024 DONE, one cycle: Stall=0, CtlValid=1, ALUCtl=1000 for MULT/MULTU or 1001 for DIV/DIVU; the input is accepted as in IDLE; next state is IDLE, or BUSY if a new multi-cycle op is accepted.
REQ-025 Multi-cycle Stall window is exactly LAT cycles; first-accept to CtlValid latency is LAT+1.
REQ-026 Counter width is clog2(64) = 6 bits; the counter SHALL NOT underflow and is used only in BUSY.
REQ-027 Flush has priority over everything: state goes to IDLE at the next edge; CtlValid, MdStart and Stall go to 0; the current input is dropped.
REQ-028 Flush in IDLE with InValid: the op is discarded and no CtlValid is produced.
REQ-029 When CtlValid=0, ALUCtl holds its last value.
REQ-030 Stall is a combinational decode of state only, with no input-to-output path.

Reset
REQ-031 rst_n low immediately forces: state IDLE; counter 0; ALUCtl=0000; CtlValid=0; IllegalOp=0; MdStart=0; MdOp=00; Stall=0.
REQ-032 Reset mid-BUSY abandons the operation; no CtlValid follows reset release.
REQ-033 The first op is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-034 Package alu_pkg holds: ALUOp encodings; funct constants; ALUCtl codes (including 1000, 1001, 1111); MdOp encodings; FSM state type.
REQ-035 One sub-module, alu_func_decode, is combinational (ALUOp, FuncCode -> code, is_md, md_op, illegal); the FSM and counter stay in alu_control_mc.

Verification
REQ-036 ALUOp=010, funct=42, InValid=1 for 1 cycle -> next cycle CtlValid=1, ALUCtl=0111, Stall=0.
REQ-037 Back-to-back ALUOp=000, 001, 011 -> ALUCtl 0010, 0110, 0000 on three consecutive cycles.
REQ-038 Funct=26, DIV_LAT=32 -> MdStart pulse with MdOp=10; Stall=1 for 32 cycles; then CtlValid=1, ALUCtl=1001.
REQ-039 Funct=24, MUL_LAT=4, then funct=32 presented during BUSY and held -> ALUCtl 1000, then 0010 on the next cycle.
REQ-040 Funct=50 -> CtlValid=1, IllegalOp=1, ALUCtl=1111; ALUOp=111 -> the same.
REQ-041 Flush at BUSY cycle 10 of DIV -> IDLE next edge with Stall=0 and no CtlValid; rst_n pulsed mid-MULT -> all outputs 0 immediately.
